// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux2 arbiter.
// Also covers the optional grant statistics enabled by MUX2_RR_ARBITER_STATS_EN.
package mux2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int BC_WIDTH = 4;
    localparam logic [BC_WIDTH-1:0] BC_MAX = '1;

    localparam int STATS_WIDTH = 16;
    localparam logic [STATS_WIDTH-1:0] STATS_SAT = 16'hFFFF;

    // Saturating increment so long-running counters stick at full scale
    function automatic logic [STATS_WIDTH-1:0] stats_inc(input logic [STATS_WIDTH-1:0] cnt);
        return (cnt == STATS_SAT) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/mux2_rr_out_stage.sv
// Single registered output slot holding the selected word and its source select.
// The slot is free when empty or when the consumer takes the word this cycle.
module mux2_rr_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_sel,
    input  logic             out_ready,
    output logic             slot_free,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel
);

    logic [WIDTH:0] word_q;

    assign slot_free = !out_valid || out_ready;
    assign out_data  = word_q[WIDTH-1:0];
    assign out_sel   = word_q[WIDTH];

    // Data and select hold after a consume; only the valid flag drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q    <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            word_q    <= {load_sel, load_data};
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with burst limit feeding a shared mux2 path into one output register.
// Define MUX2_RR_ARBITER_STATS_EN to add per-requester grant counters with a clear input.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ0_VALID,
    input  logic [WIDTH-1:0]       REQ0_DATA,
    output logic                   REQ0_READY,
    input  logic                   REQ1_VALID,
    input  logic [WIDTH-1:0]       REQ1_DATA,
    output logic                   REQ1_READY,
    output logic                   OUT_VALID,
    output logic [WIDTH-1:0]       OUT_DATA,
    output logic                   OUT_SEL,
`ifdef MUX2_RR_ARBITER_STATS_EN
    input  logic                   OUT_READY,
    input  logic                   STATS_CLR,
    output logic [STATS_WIDTH-1:0] GNT0_CNT,
    output logic [STATS_WIDTH-1:0] GNT1_CNT
`else
    input  logic                   OUT_READY
`endif
);

    localparam logic [BC_WIDTH-1:0] BURST_LIMIT = BC_WIDTH'(MAX_BURST);

    arb_state_e          state, state_next;
    logic [BC_WIDTH-1:0] bc, bc_next;
    logic                slot_free;
    logic                grant;
    logic                transfer;
    logic                burst_left;
    logic                grant_is_owner;
    logic [WIDTH-1:0]    sel_data;

    assign burst_left = bc < BURST_LIMIT;

    // Contention goes to the current owner until its burst allowance runs out
    always_comb begin
        grant = 1'b0;
        if (REQ0_VALID && REQ1_VALID) begin
            case (state)
                OWN0:    grant = !burst_left;
                OWN1:    grant = burst_left;
                default: grant = 1'b0;
            endcase
        end else if (REQ1_VALID) begin
            grant = 1'b1;
        end
    end

    assign transfer       = slot_free && (grant ? REQ1_VALID : REQ0_VALID);
    assign REQ0_READY     = !RST && transfer && !grant;
    assign REQ1_READY     = !RST && transfer && grant;
    assign sel_data       = grant ? REQ1_DATA : REQ0_DATA;
    assign grant_is_owner = (grant && state == OWN1) || (!grant && state == OWN0);

    always_comb begin
        state_next = state;
        bc_next    = bc;
        if (transfer) begin
            if (grant_is_owner) begin
                bc_next = (bc == BC_MAX) ? bc : bc + 1'b1;
            end else begin
                state_next = grant ? OWN1 : OWN0;
                bc_next    = BC_WIDTH'(1);
            end
        end else if (!REQ0_VALID && !REQ1_VALID) begin
            state_next = IDLE;
            bc_next    = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            bc    <= '0;
        end else begin
            state <= state_next;
            bc    <= bc_next;
        end
    end

    mux2_rr_out_stage #(
        .WIDTH(WIDTH)
    ) u_out_stage (
        .clk       (CLK),
        .rst       (RST),
        .load      (transfer),
        .load_data (sel_data),
        .load_sel  (grant),
        .out_ready (OUT_READY),
        .slot_free (slot_free),
        .out_valid (OUT_VALID),
        .out_data  (OUT_DATA),
        .out_sel   (OUT_SEL)
    );

`ifdef MUX2_RR_ARBITER_STATS_EN
    // A clear in the same cycle as a transfer wins over the increment
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT0_CNT <= '0;
            GNT1_CNT <= '0;
        end else if (STATS_CLR) begin
            GNT0_CNT <= '0;
            GNT1_CNT <= '0;
        end else if (transfer) begin
            if (grant) begin
                GNT1_CNT <= stats_inc(GNT1_CNT);
            end else begin
                GNT0_CNT <= stats_inc(GNT0_CNT);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: cycle vector table with a word scoreboard,
// plus hand sequences for mid-transfer reset and (when enabled) the grant counters.
module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int NUM_VECS  = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             out_valid, out_sel, out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef MUX2_RR_ARBITER_STATS_EN
    logic             stats_clr;
    logic [15:0]      gnt0_cnt, gnt1_cnt;
`endif

    typedef struct {
        logic             v0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [WIDTH-1:0] d1;
        logic             ordy;
        logic             e_rdy0;
        logic             e_rdy1;
        logic             e_ovalid;
    } vec_t;

    typedef struct {
        logic             sel;
        logic [WIDTH-1:0] data;
    } word_t;

    vec_t  vecs [NUM_VECS];
    word_t sb [$];
    word_t exp_word;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .REQ0_VALID (req0_valid),
        .REQ0_DATA  (req0_data),
        .REQ0_READY (req0_ready),
        .REQ1_VALID (req1_valid),
        .REQ1_DATA  (req1_data),
        .REQ1_READY (req1_ready),
        .OUT_VALID  (out_valid),
        .OUT_DATA   (out_data),
        .OUT_SEL    (out_sel),
`ifdef MUX2_RR_ARBITER_STATS_EN
        .OUT_READY  (out_ready),
        .STATS_CLR  (stats_clr),
        .GNT0_CNT   (gnt0_cnt),
        .GNT1_CNT   (gnt1_cnt)
`else
        .OUT_READY  (out_ready)
`endif
    );

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        req0_valid = v.v0;
        req0_data  = v.d0;
        req1_valid = v.v1;
        req1_data  = v.d1;
        out_ready  = v.ordy;
    endtask

    task automatic set_vec(input int i, input logic v0, input logic v1, input logic ordy,
                           input logic r0, input logic r1, input logic ov);
        vecs[i].v0       = v0;
        vecs[i].d0       = 8'h10 + 8'(i);
        vecs[i].v1       = v1;
        vecs[i].d1       = 8'h80 + 8'(i);
        vecs[i].ordy     = ordy;
        vecs[i].e_rdy0   = r0;
        vecs[i].e_rdy1   = r1;
        vecs[i].e_ovalid = ov;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        // Burst of 4 each way, 3-cycle stall, lone REQ1, idle gap, then lone REQ0 under backpressure
        set_vec(0,  1, 1, 1, 1, 0, 0);
        set_vec(1,  1, 1, 1, 1, 0, 1);
        set_vec(2,  1, 1, 1, 1, 0, 1);
        set_vec(3,  1, 1, 1, 1, 0, 1);
        set_vec(4,  1, 1, 1, 0, 1, 1);
        set_vec(5,  1, 1, 1, 0, 1, 1);
        set_vec(6,  1, 1, 1, 0, 1, 1);
        set_vec(7,  1, 1, 1, 0, 1, 1);
        set_vec(8,  1, 1, 1, 1, 0, 1);
        set_vec(9,  1, 1, 0, 0, 0, 1);
        set_vec(10, 1, 1, 0, 0, 0, 1);
        set_vec(11, 1, 1, 0, 0, 0, 1);
        set_vec(12, 1, 1, 1, 1, 0, 1);
        set_vec(13, 0, 1, 1, 0, 1, 1);
        vecs[13].d1 = 8'hA5;
        set_vec(14, 0, 0, 1, 0, 0, 1);
        set_vec(15, 1, 1, 1, 1, 0, 0);
        set_vec(16, 0, 0, 0, 0, 0, 1);
        set_vec(17, 1, 0, 0, 0, 0, 1);
        set_vec(18, 1, 0, 1, 1, 0, 1);
        set_vec(19, 0, 0, 1, 0, 0, 1);
        set_vec(20, 0, 0, 1, 0, 0, 0);

        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        req1_valid = 1'b1;
        req1_data  = 8'h22;
        out_ready  = 1'b1;
`ifdef MUX2_RR_ARBITER_STATS_EN
        stats_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_output("reset_ready0", 16'(req0_ready), 16'd0);
        check_output("reset_ready1", 16'(req1_ready), 16'd0);
        check_output("reset_out_valid", 16'(out_valid), 16'd0);
        rst = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("v%0d_ready0", i), 16'(req0_ready), 16'(vecs[i].e_rdy0));
            check_output($sformatf("v%0d_ready1", i), 16'(req1_ready), 16'(vecs[i].e_rdy1));
            check_output($sformatf("v%0d_out_valid", i), 16'(out_valid), 16'(vecs[i].e_ovalid));
            if (vecs[i].e_ovalid && vecs[i].ordy) begin
                if (sb.size() == 0) begin
                    check_output($sformatf("v%0d_sb_underflow", i), 16'd0, 16'd1);
                end else begin
                    exp_word = sb.pop_front();
                    check_output($sformatf("v%0d_out_data", i), 16'(out_data), 16'(exp_word.data));
                    check_output($sformatf("v%0d_out_sel", i), 16'(out_sel), 16'(exp_word.sel));
                end
            end
            if (vecs[i].e_rdy0) sb.push_back('{1'b0, vecs[i].d0});
            if (vecs[i].e_rdy1) sb.push_back('{1'b1, vecs[i].d1});
            @(negedge clk);
        end
        check_output("sb_empty", 16'(sb.size()), 16'd0);
        #1;
        check_output("hold_out_data", 16'(out_data), 16'(vecs[18].d0));
        check_output("hold_out_sel", 16'(out_sel), 16'd0);

        // Load a word from requester 1, then reset with both requesters pending
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 8'h5C;
        out_ready  = 1'b1;
        #1;
        check_output("pre_rst_ready1", 16'(req1_ready), 16'd1);
        @(negedge clk);
        #1;
        check_output("pre_rst_out_valid", 16'(out_valid), 16'd1);
        check_output("pre_rst_out_sel", 16'(out_sel), 16'd1);
        req0_valid = 1'b1;
        req0_data  = 8'h3C;
        rst        = 1'b1;
        #1;
        check_output("mid_rst_out_valid", 16'(out_valid), 16'd0);
        check_output("mid_rst_out_data", 16'(out_data), 16'd0);
        check_output("mid_rst_out_sel", 16'(out_sel), 16'd0);
        check_output("mid_rst_ready0", 16'(req0_ready), 16'd0);
        check_output("mid_rst_ready1", 16'(req1_ready), 16'd0);
        @(negedge clk);
        #1;
        check_output("rst_edge_out_valid", 16'(out_valid), 16'd0);
        rst = 1'b0;
        #1;
        check_output("post_rst_ready0", 16'(req0_ready), 16'd1);
        check_output("post_rst_ready1", 16'(req1_ready), 16'd0);
        @(negedge clk);
        #1;
        check_output("post_rst_out_valid", 16'(out_valid), 16'd1);
        check_output("post_rst_out_sel", 16'(out_sel), 16'd0);
        check_output("post_rst_out_data", 16'(out_data), 16'h3C);

`ifdef MUX2_RR_ARBITER_STATS_EN
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        out_ready  = 1'b1;
        req0_valid = 1'b1;
        repeat (5) @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check_output("gnt0_cnt", gnt0_cnt, 16'd5);
        check_output("gnt1_cnt", gnt1_cnt, 16'd3);
        stats_clr  = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        #1;
        check_output("clr_gnt0_cnt", gnt0_cnt, 16'd0);
        check_output("clr_gnt1_cnt", gnt1_cnt, 16'd0);
        stats_clr  = 1'b0;
        req0_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
